dma_ctrl: RTL

- Memory-to-memory / memory-to-I/O DMA engine and bus arbiter for the 6502 system.
- The CPU programs it through an 8-register slave window at $FE40-$FE47.
- On start, it stalls the CPU via RDY, takes ownership of the shared addr/dbw/we bus, copies LEN bytes from SRC to DST, then returns the bus and raises done/IRQ.
- The system mux selects m_addr/m_dbw/m_we whenever bus_own=1.

---
 rtl/dma_ctrl_pkg.sv | 42 ++++
 rtl/dma_ctrl_if.sv | 31 +++
 rtl/dma_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dma_ctrl_pkg.sv
// Shared definitions for the DMA controller: widths, register offsets,
// CTRL/STATUS bit positions and the transfer FSM state encoding.
package dma_ctrl_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_W  = 3;

  // Slave register offsets within the 8-byte window
  localparam logic [REG_W-1:0] REG_SRCL   = 3'd0;
  localparam logic [REG_W-1:0] REG_SRCH   = 3'd1;
  localparam logic [REG_W-1:0] REG_DSTL   = 3'd2;
  localparam logic [REG_W-1:0] REG_DSTH   = 3'd3;
  localparam logic [REG_W-1:0] REG_LENL   = 3'd4;
  localparam logic [REG_W-1:0] REG_LENH   = 3'd5;
  localparam logic [REG_W-1:0] REG_CTRL   = 3'd6;
  localparam logic [REG_W-1:0] REG_STATUS = 3'd7;

  // CTRL bits
  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_IEN     = 1;
  localparam int unsigned CTRL_SRC_FIX = 2;
  localparam int unsigned CTRL_DST_FIX = 3;

  // STATUS bits
  localparam int unsigned STAT_DONE = 0;
  localparam int unsigned STAT_BUSY = 7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_RD   = 3'd2,
    S_HOLD = 3'd3,
    S_WR   = 3'd4
  } state_e;

  // True for the states in which the DMA owns the system bus
  function automatic logic owns_bus(input state_e s);
    return (s == S_RD) || (s == S_HOLD) || (s == S_WR);
  endfunction

endpackage

// File: rtl/dma_ctrl_if.sv
// Bus bundle for the DMA controller.
//   Slave window : addr, dbw, we (CPU -> DMA), dbr (DMA -> CPU)
//   CPU control  : cpu_rdy, irq
//   Master bus   : bus_own, m_addr, m_dbw, m_we (DMA -> system), m_dbr (system -> DMA)
// modport slave is the DMA side; modport master is the system/CPU side.
interface dma_ctrl_if;
  import dma_ctrl_pkg::*;

  logic [DATA_W-1:0] dbr;
  logic [DATA_W-1:0] dbw;
  logic [REG_W-1:0]  addr;
  logic              we;
  logic              cpu_rdy;
  logic              bus_own;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dbw;
  logic              m_we;
  logic [DATA_W-1:0] m_dbr;
  logic              irq;

  modport slave (
    input  dbw, addr, we, m_dbr,
    output dbr, cpu_rdy, bus_own, m_addr, m_dbw, m_we, irq
  );

  modport master (
    output dbw, addr, we, m_dbr,
    input  dbr, cpu_rdy, bus_own, m_addr, m_dbw, m_we, irq
  );

endinterface

// File: rtl/dma_ctrl.sv
// dma_ctrl: memory-to-memory DMA engine and bus arbiter.
// The CPU programs SRC/DST/LEN/CTRL through the slave window; a start
// stalls the CPU, copies LEN bytes (3 cycles each: RD, HOLD, WR) and then
// releases the bus and raises done (and irq when enabled).
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - dma_ctrl_if.slave (slave window, cpu_rdy, irq, master bus)
module dma_ctrl
  import dma_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  dma_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              ien_q, ien_d;
  logic              src_fix_q, src_fix_d;
  logic              dst_fix_q, dst_fix_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] dbr_q, dbr_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_dbw_q, m_dbw_d;
  logic              m_we_q, m_we_d;
  logic              bus_own_q, bus_own_d;
  logic              cpu_rdy_q, cpu_rdy_d;
  logic              busy_c;

  assign busy_c = (state_q != S_IDLE);

  // State and register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      ien_q     <= 1'b0;
      src_fix_q <= 1'b0;
      dst_fix_q <= 1'b0;
      done_q    <= 1'b0;
      dbr_q     <= '0;
      m_addr_q  <= '0;
      m_dbw_q   <= '0;
      m_we_q    <= 1'b0;
      bus_own_q <= 1'b0;
      cpu_rdy_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      ien_q     <= ien_d;
      src_fix_q <= src_fix_d;
      dst_fix_q <= dst_fix_d;
      done_q    <= done_d;
      dbr_q     <= dbr_d;
      m_addr_q  <= m_addr_d;
      m_dbw_q   <= m_dbw_d;
      m_we_q    <= m_we_d;
      bus_own_q <= bus_own_d;
      cpu_rdy_q <= cpu_rdy_d;
    end
  end

  // Next state, register updates and next-cycle bus outputs
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    ien_d     = ien_q;
    src_fix_d = src_fix_q;
    dst_fix_d = dst_fix_q;
    done_d    = done_q;
    m_dbw_d   = m_dbw_q;
    m_addr_d  = m_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.we) begin
          case (bus.addr)
            REG_SRCL: src_d[7:0]  = bus.dbw;
            REG_SRCH: src_d[15:8] = bus.dbw;
            REG_DSTL: dst_d[7:0]  = bus.dbw;
            REG_DSTH: dst_d[15:8] = bus.dbw;
            REG_LENL: len_d[7:0]  = bus.dbw;
            REG_LENH: len_d[15:8] = bus.dbw;
            REG_CTRL: begin
              ien_d     = bus.dbw[CTRL_IEN];
              src_fix_d = bus.dbw[CTRL_SRC_FIX];
              dst_fix_d = bus.dbw[CTRL_DST_FIX];
              if (bus.dbw[CTRL_START]) begin
                // A zero-length start completes at once without touching the bus
                if (len_q != '0) begin
                  done_d  = 1'b0;
                  state_d = S_SYNC;
                end else begin
                  done_d  = 1'b1;
                end
              end
            end
            default: done_d = 1'b0;   // STATUS write clears done
          endcase
        end
      end
      S_SYNC: state_d = S_RD;
      S_RD:   state_d = S_HOLD;
      S_HOLD: begin
        // Read data is valid one cycle after the address was presented
        m_dbw_d = bus.m_dbr;
        state_d = S_WR;
      end
      S_WR: begin
        src_d = src_fix_q ? src_q : ADDR_W'(src_q + ADDR_W'(1));
        dst_d = dst_fix_q ? dst_q : ADDR_W'(dst_q + ADDR_W'(1));
        len_d = ADDR_W'(len_q - ADDR_W'(1));
        if (len_q == ADDR_W'(1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so derive them from the state being entered
    cpu_rdy_d = (state_d == S_IDLE);
    bus_own_d = owns_bus(state_d);
    m_we_d    = (state_d == S_WR);
    if ((state_d == S_RD) || (state_d == S_HOLD)) begin
      m_addr_d = src_d;
    end else if (state_d == S_WR) begin
      m_addr_d = dst_d;
    end
  end

  // Slave read mux, registered to line up with the registered chip select
  always_comb begin
    dbr_d = '0;
    case (bus.addr)
      REG_SRCL: dbr_d = src_q[7:0];
      REG_SRCH: dbr_d = src_q[15:8];
      REG_DSTL: dbr_d = dst_q[7:0];
      REG_DSTH: dbr_d = dst_q[15:8];
      REG_LENL: dbr_d = len_q[7:0];
      REG_LENH: dbr_d = len_q[15:8];
      REG_CTRL: begin
        dbr_d[CTRL_IEN]     = ien_q;
        dbr_d[CTRL_SRC_FIX] = src_fix_q;
        dbr_d[CTRL_DST_FIX] = dst_fix_q;
      end
      default: begin
        dbr_d[STAT_BUSY] = busy_c;
        dbr_d[STAT_DONE] = done_q;
      end
    endcase
  end

  assign bus.dbr     = dbr_q;
  assign bus.cpu_rdy = cpu_rdy_q;
  assign bus.bus_own = bus_own_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_dbw   = m_dbw_q;
  assign bus.m_we    = m_we_q;
  assign bus.irq     = done_q & ien_q;

endmodule
